// File: rtl/jt12_ring_ctl_pkg.sv
// Shared constants, FSM state type and slot mapping for the 24-slot parameter ring.
package jt12_ring_ctl_pkg;
    localparam int NCH    = 6;
    localparam int NOP    = 4;
    localparam int SLOTS  = NCH * NOP;
    localparam int SLOT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_CLEAR_WAIT,
        ST_CLEAR
    } ring_state_t;

    // Operators are the slow index: slot = op*6 + ch.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [2:0] ch, input logic [1:0] op);
        return SLOT_W'(op) * SLOT_W'(NCH) + SLOT_W'(ch);
    endfunction
endpackage

// File: rtl/jt12_ring_ctl_slot_cnt.sv
// Mod-24 slot counter with enable and a registered slot-zero flag.
module jt12_slot_cnt
    import jt12_ring_ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    output logic [SLOT_W-1:0] slot,
    output logic              zero
);
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              zero_q, zero_d;

    always_comb begin
        slot_d = slot_q;
        if (clk_en) begin
            slot_d = (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + 1'b1;
        end
        // Computed from the next slot so the flag lines up with the registered count.
        zero_d = (slot_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            zero_q <= 1'b1;
        end else begin
            slot_q <= slot_d;
            zero_q <= zero_d;
        end
    end

    assign slot = slot_q;
    assign zero = zero_q;
endmodule

// File: rtl/jt12_ring_ctl.sv
// Ring controller: owns the slot counter and splices CPU writes or a full clear
// into the recirculating parameter delay line at the targeted slot.
module jt12_ring_ctl
    import jt12_ring_ctl_pkg::*;
#(
    parameter int               width  = 7,
    parameter logic [width-1:0] CLRVAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              wr_req,
    input  logic [2:0]        wr_ch,
    input  logic [1:0]        wr_op,
    input  logic [width-1:0]  wr_data,
    input  logic              clr_req,
    output logic              wr_busy,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [SLOT_W-1:0] slot,
    output logic              zero,
    input  logic [width-1:0]  ring_drop,
    output logic [width-1:0]  ring_din
);
    ring_state_t       state_q;
    logic [SLOT_W-1:0] tgt_q;
    logic [width-1:0]  data_q;
    logic              ack_q;
    logic              err_q;

    logic hit_pend;
    logic clr_word;

    jt12_slot_cnt u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .slot   (slot),
        .zero   (zero)
    );

    // The slot-0 cycle of CLEAR_WAIT already writes CLRVAL; CLEAR then covers 1..23.
    always_comb begin
        hit_pend = clk_en && (state_q == ST_PEND) && (slot == tgt_q);
        clr_word = clk_en && ((state_q == ST_CLEAR) ||
                              ((state_q == ST_CLEAR_WAIT) && (slot == '0)));
        ring_din = ring_drop;
        if (hit_pend) begin
            ring_din = data_q;
        end else if (clr_word) begin
            ring_din = CLRVAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (clk_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (clr_req) begin
                            state_q <= ST_CLEAR_WAIT;
                        end else if (wr_req) begin
                            if (wr_ch < 3'(NCH)) begin
                                tgt_q   <= slot_of(wr_ch, wr_op);
                                data_q  <= wr_data;
                                state_q <= ST_PEND;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (slot == tgt_q) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_CLEAR_WAIT: begin
                        if (slot == '0) begin
                            state_q <= ST_CLEAR;
                        end
                    end
                    ST_CLEAR: begin
                        if (slot == SLOT_W'(SLOTS - 1)) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_busy = (state_q != ST_IDLE);
    assign wr_ack  = ack_q;
    assign wr_err  = err_q;
endmodule

// File: tb/tb_jt12_ring_ctl.sv
// Scoreboard bench for jt12_ring_ctl with a behavioural 24-slot ring around it.
module tb_jt12_ring_ctl;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_ch = '0;
    logic [1:0]   wr_op = '0;
    logic [W-1:0] wr_data = '0;
    logic         clr_req = 1'b0;
    logic         wr_busy, wr_ack, wr_err, zero;
    logic [4:0]   slot;
    logic [W-1:0] ring_drop, ring_din;

    logic [W-1:0] ring_mem [24];
    bit           mem_ready = 1'b0;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           mon_on = 1'b0;

    typedef enum int {EV_WR, EV_ACK, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        int           cyc;
        logic [4:0]   slot;
        logic [W-1:0] data;
    } ev_t;
    ev_t exp_q[$];

    jt12_ring_ctl #(.width(W), .CLRVAL(7'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .wr_req    (wr_req),
        .wr_ch     (wr_ch),
        .wr_op     (wr_op),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .wr_busy   (wr_busy),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .slot      (slot),
        .zero      (zero),
        .ring_drop (ring_drop),
        .ring_din  (ring_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring storage: every slot starts with a distinct non-zero word (slot+1).
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 24; i++) ring_mem[i] <= W'(i + 1);
            mem_ready <= 1'b1;
        end else if (clk_en && slot < 5'd24) begin
            ring_mem[slot] <= ring_din;
        end
    end
    assign ring_drop = (slot < 5'd24) ? ring_mem[slot] : '0;

    function automatic void push(ev_kind_t k, int c, int s, logic [W-1:0] d);
        ev_t e;
        e.kind = k; e.cyc = c; e.slot = 5'(s); e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic got(ev_kind_t k, logic [4:0] s, logic [W-1:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s cyc=%0d slot=%0d data=%0h, required none",
                     k.name(), cyc, s, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.slot !== s || e.data !== d) begin
                bad++;
                $display("FAIL event: got %s cyc=%0d slot=%0d data=%0h, required %s cyc=%0d slot=%0d data=%0h",
                         k.name(), cyc, s, d, e.kind.name(), e.cyc, e.slot, e.data);
            end else begin
                $display("ok %s cyc=%0d slot=%0d data=%0h", k.name(), cyc, s, d);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (wr_ack) got(EV_ACK, slot, '0);
                if (wr_err) got(EV_ERR, slot, '0);
                if (clk_en && ring_din !== ring_drop) got(EV_WR, slot, ring_din);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(int s);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (slot == 5'(s)) found = 1'b1;
            else step();
        end
        if (!found) check("wait_slot_timeout", 32'(slot), 32'(s));
    endtask

    task automatic wait_drain(int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int       n;
        bit       fired;
        logic [4:0] prev;

        fork
            monitor();
        join_none

        // Reset with the enable high; state must come out clean.
        rst = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        check("rst_slot", 32'(slot), 0);
        check("rst_zero", 32'(zero), 1);
        check("rst_busy", 32'(wr_busy), 0);
        check("rst_ack", 32'(wr_ack), 0);
        check("rst_err", 32'(wr_err), 0);
        rst = 1'b0;

        // Free-running count for 50 enabled cycles.
        for (int i = 0; i < 50; i++) begin
            check("count_slot", 32'(slot), 32'(i % 24));
            check("count_zero", 32'(zero), 32'(i % 24 == 0));
            step();
        end

        // Write ch=2 op=1 (slot 8) issued at slot 5.
        wait_slot(5);
        n = cyc;
        wr_req = 1'b1; wr_ch = 3'd2; wr_op = 2'd1; wr_data = 7'h55;
        push(EV_WR, n + 3, 8, 7'h55);
        push(EV_ACK, n + 4, 9, '0);
        step();
        wr_req = 1'b0;
        check("pend_busy", 32'(wr_busy), 1);
        wait_drain(40);
        check("post_ack_busy", 32'(wr_busy), 0);
        wait_slot(8);
        check("readback_8", 32'(ring_drop), 32'h55);

        // Write to slot 10 latched while at slot 10: full revolution.
        wait_slot(10);
        n = cyc;
        wr_req = 1'b1; wr_ch = 3'd4; wr_op = 2'd1; wr_data = 7'h2A;
        push(EV_WR, n + 24, 10, 7'h2A);
        push(EV_ACK, n + 25, 11, '0);
        step();
        wr_req = 1'b0;
        wait_drain(40);

        // Out-of-range channels are rejected with a single error pulse.
        wait_slot(14);
        n = cyc;
        wr_req = 1'b1; wr_ch = 3'd6; wr_op = 2'd0; wr_data = 7'h7F;
        push(EV_ERR, n + 1, 15, '0);
        step();
        wr_req = 1'b0;
        check("err_busy", 32'(wr_busy), 0);
        wait_drain(5);
        wait_slot(16);
        n = cyc;
        wr_req = 1'b1; wr_ch = 3'd7; wr_op = 2'd2; wr_data = 7'h01;
        push(EV_ERR, n + 1, 17, '0);
        step();
        wr_req = 1'b0;
        check("err_busy_7", 32'(wr_busy), 0);
        wait_drain(5);

        // Clear and write together at slot 3: clear wins, write is dropped.
        wait_slot(3);
        n = cyc;
        clr_req = 1'b1; wr_req = 1'b1; wr_ch = 3'd0; wr_op = 2'd0; wr_data = 7'h11;
        for (int k = 0; k < 24; k++) push(EV_WR, n + 21 + k, k, 7'h00);
        push(EV_ACK, n + 45, 0, '0);
        step();
        clr_req = 1'b0; wr_req = 1'b0;
        check("clr_wait_busy", 32'(wr_busy), 1);
        repeat (4) step();
        // Requests while busy must be ignored, not queued.
        wr_req = 1'b1; wr_ch = 3'd1; wr_data = 7'h33;
        repeat (2) step();
        wr_req = 1'b0;
        wait_drain(60);
        check("clr_done_busy", 32'(wr_busy), 0);
        wait_slot(8);
        check("readback_clr_8", 32'(ring_drop), 0);

        // Pending write with a gated enable, aborted by reset just before commit.
        wait_slot(12);
        wr_req = 1'b1; wr_ch = 3'd3; wr_op = 2'd3; wr_data = 7'h66;
        step();
        wr_req = 1'b0;
        check("abort_pend_busy", 32'(wr_busy), 1);
        fired = 1'b0;
        for (int i = 0; i < 100 && !fired; i++) begin
            prev = slot;
            clk_en = ~clk_en;
            if (clk_en && slot == 5'd20) begin
                rst = 1'b1;
                fired = 1'b1;
            end
            step();
            if (!fired) begin
                if (clk_en) check("gated_adv", 32'(slot), 32'((prev + 5'd1) % 5'd24));
                else        check("gated_hold", 32'(slot), 32'(prev));
            end
        end
        if (!fired) check("abort_timeout", 0, 1);
        rst = 1'b0;
        clk_en = 1'b1;
        check("abort_slot", 32'(slot), 0);
        check("abort_zero", 32'(zero), 1);
        check("abort_busy", 32'(wr_busy), 0);
        repeat (30) step();
        check("abort_idle_busy", 32'(wr_busy), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jt12_ring_ctl.md
# jt12_ring_ctl

Controller for a 24-slot time-division parameter ring built from a recirculating delay line (6 channels × 4 operators). It owns the slot counter, recirculates the ring word every enabled cycle and splices in CPU parameter writes or a full-ring clear at the exact slot they target. It sits between the register interface and each per-operator parameter delay line in the FM core.

## Interface
- `width`, 7: bits per ring word.
- `CLRVAL`, 0: word written to every slot by a clear.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `clk_en`  in  1: slot advance enable; all state except the handshake outputs holds when low.
- `wr_req`  in  1: write request, level; sampled when `wr_busy`=0.
- `wr_ch`  in  3: target channel 0..5.
- `wr_op`  in  2: target operator 0..3.
- `wr_data`  in  width: word to store.
- `clr_req`  in  1: clear-all request, sampled when `wr_busy`=0.
- `wr_busy`  out  1: pending write or clear in progress.
- `wr_ack`  out  1: one-cycle pulse when a write or clear completes.
- `wr_err`  out  1: one-cycle pulse when a write with `wr_ch`>5 is rejected.
- `slot`  out  5: current slot 0..23.
- `zero`  out  1: high while `slot`==0.
- `ring_drop`  in  width: word for the current slot from the external 24-stage delay line.
- `ring_din`  out  width: word fed back into the delay line (combinational).

## Operation
- Slot mapping: slot = op*6 + ch. `slot` increments on each `clk_en` cycle, 23 wraps to 0.
- FSM states: IDLE, PEND, CLEAR_WAIT, CLEAR.
- IDLE: `clr_req`=1 → CLEAR_WAIT (clear wins if `wr_req` is also high). Else `wr_req`=1 with `wr_ch`<=5 → latch ch/op/data, go to PEND. Else `wr_req`=1 with `wr_ch`>5 → `wr_err` pulse next cycle, stay IDLE.
- PEND: on a `clk_en` cycle with `slot`==target, `ring_din`=latched data, `wr_ack` pulses next cycle, go to IDLE.
- CLEAR_WAIT: on a `clk_en` cycle with `slot`==0, enter CLEAR and drive `ring_din`=CLRVAL for that cycle.
- CLEAR: `ring_din`=CLRVAL on every enabled cycle. After slot 23 is written, `wr_ack` pulses and the FSM goes to IDLE.
- In all other cases `ring_din`=`ring_drop`, so the ring recirculates.
- `wr_busy`=1 in PEND, CLEAR_WAIT and CLEAR. Requests are ignored while busy; they are not queued.
- `clk_en` low: `slot`, the FSM and the pending data hold. No commit happens. `ring_din`=`ring_drop` (value is don't-care).

## Timing
- Reset (synchronous, edge with `rst`=1): `slot`=0, `zero`=1, FSM=IDLE, `wr_busy`=0, `wr_ack`=0, `wr_err`=0.
- Reset mid-write or mid-clear aborts it with no ack. Ring contents already written stay.
- Request is latched at edge N. The commit cannot occur in the cycle of edge N; the earliest commit is the first enabled cycle after it.
- Write latency: 1..24 enabled cycles from latch to commit. `wr_ack` is asserted on the clock after the commit.
- Clear latency: up to 24 enabled cycles waiting for slot 0, then 24 enabled cycles of writes.
- `wr_err` is asserted on the cycle after the request is sampled. `wr_busy` stays 0.
- `zero` and `slot` are registered. `ring_din` is combinational from the state, `slot`, `clk_en` and `ring_drop`.

## Structure
- Shared package: `SLOTS`=24, `NCH`=6, `NOP`=4, the FSM state enum, and the slot-from-ch/op function.
- Sub-module `jt12_slot_cnt`: mod-24 counter with `clk_en` advance, `zero` flag and synchronous reset.
- The delay line stays outside this block, instantiated with 24 stages.

## Test plan
- Reset, then `clk_en` held at 1 for 50 cycles → `slot` counts 0..23, 0..23, 0, 1. `zero` is high at cycles 0, 24 and 48.
- With `slot`=5, write ch=2 op=1 data=0x55 → commit at slot 8 with `ring_din`=0x55. `wr_ack` follows one cycle later. Ring read-back at the next slot 8 gives 0x55.
- Write targeting slot 10, latched while `slot`=10 → commit at the next slot 10, 24 enabled cycles later.
- `wr_ch`=6 → `wr_err` pulse next cycle, `wr_busy` stays 0, ring unchanged.
- `clr_req` and `wr_req` asserted together with `slot`=3 → the clear wins. It waits 21 enabled cycles, writes CLRVAL to all 24 slots, then `wr_ack` pulses. The write is dropped.
- `clk_en` toggled 1/0 during PEND, with `rst` asserted one cycle before commit → no ack, FSM=IDLE, `slot`=0.
